serial_addsub_ctrl: RTL and testbench
=====================================

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin an operation.
REQ-005 op  input  1  operation select: 0 = add (a_in + b_in), 1 = subtract (a_in - b_in).
REQ-006 a_in  input  WIDTH  first operand, unsigned.
REQ-007 b_in  input  WIDTH  second operand, unsigned.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE state).
REQ-009 done  output  1  single-cycle pulse marking result/carry_out valid.
REQ-010 result  output  WIDTH  final sum or difference.
REQ-011 carry_out  output  1  final carry (add) or final borrow (subtract).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE; the reset state SHALL be IDLE.
REQ-013 IDLE: if start=1 at a rising edge k, the block SHALL latch a_in, b_in and op, clear the internal carry/borrow bit to 0, clear the bit counter to 0, and enter RUN.
REQ-014 IDLE with start=0 SHALL remain in IDLE with no change to any output.
REQ-015 RUN: on each edge the block SHALL process one bit, LSB first, using latched operand bit a_i, b_i and the stored carry/borrow c.
REQ-016 Add bit rule: s = a_i ^ b_i ^ c; next c = (a_i & b_i) | (c & (a_i ^ b_i)).
REQ-017 Subtract bit rule: d = a_i ^ b_i ^ c; next c = (~a_i & b_i) | (~(a_i ^ b_i) & c).
REQ-018 Each processed bit SHALL be shifted into an internal shift register at the MSB end (right shift), so after WIDTH bits bit i sits at position i.
REQ-019 After the edge that processes bit WIDTH-1 (edge k+WIDTH), the FSM SHALL enter DONE, load result from the internal shift register (including the final bit), and load carry_out from the final carry/borrow.
REQ-020 DONE: done SHALL be 1 for exactly this one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-021 result and carry_out SHALL change only at the DONE-entry edge, and SHALL hold between operations; intermediate bits SHALL NOT be visible on result.
REQ-022 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-023 start, op, a_in, b_in SHALL be ignored while busy=1; operand changes after acceptance SHALL NOT affect the running operation.
REQ-024 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH; with start held high continuously, one operation SHALL be accepted every WIDTH+2 cycles.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; an overflow on add sets carry_out=1, a negative difference on subtract sets carry_out=1 and result = two's-complement wrap.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, result=0, carry_out=0, and clear the bit counter, carry/borrow bit, shift register and latched operands.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 op=0, a_in=0x5A, b_in=0x3C, start pulsed at edge k -> result=0x96, carry_out=0, done high only in the cycle after edge k+8, busy high from k to k+9.
REQ-029 op=0, 0xFF + 0x01 -> result=0x00, carry_out=1; op=0, 0x00 + 0x00 -> result=0x00, carry_out=0.
REQ-030 op=1, 0x10 - 0x01 -> result=0x0F, carry_out=0; op=1, 0x00 - 0x01 -> result=0xFF, carry_out=1.
REQ-031 Start 0x12+0x34, then during RUN drive start=1, op=1, a_in=0xFF, b_in=0xFF -> that request ignored, result=0x46, carry_out=0.
REQ-032 Start 0x5A+0x3C, assert rst_n=0 after 4 RUN edges -> busy, done, result, carry_out go 0 asynchronously; no done pulse; after release, 0x01+0x02 -> result=0x03.
REQ-033 start held at 1 with fixed operands for 30 cycles -> done pulses exactly every 10 cycles, result constant.

Source files
------------

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one operand bit per clock, LSB first, with a
// three-state controller that presents the full result and carry/borrow at once.
module serial_addsub_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             op_q;
   logic             c_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sr_q;

   logic             a_bit;
   logic             b_bit;
   logic             s_bit;
   logic             c_next;
   logic [WIDTH-1:0] sr_next;

   // Operands shift right each RUN cycle, so bit 0 is always the current bit.
   always_comb begin
      a_bit   = a_q[0];
      b_bit   = b_q[0];
      s_bit   = a_bit ^ b_bit ^ c_q;
      c_next  = 1'b0;
      if (op_q) begin
         c_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_q);
      end else begin
         c_next = (a_bit & b_bit) | (c_q & (a_bit ^ b_bit));
      end
      sr_next = {s_bit, sr_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= 1'b0;
         c_q       <= 1'b0;
         cnt_q     <= '0;
         sr_q      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  a_q     <= a_in;
                  b_q     <= b_in;
                  op_q    <= op;
                  c_q     <= 1'b0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               c_q   <= c_next;
               sr_q  <= sr_next;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastBit) begin
                  // Final bit goes straight to result; sr_q never leaks out mid-op.
                  result    <= sr_next;
                  carry_out <= c_next;
                  done      <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_addsub_ctrl;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;

   int checks = 0;
   int errors = 0;

   serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start at a negedge, then verify busy, latency, result and carry.
   task automatic run_op(input string tag, input logic o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ec);
      int n;
      @(negedge clk);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(negedge clk);
      start = 1'b0; op = ~o; a_in = ~a; b_in = ~b;
      chk({tag, "_busy_k"}, busy, 1);
      chk({tag, "_done_k"}, done, 0);
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            break;
         end
      end
      chk({tag, "_latency"}, n, 8);
      chk({tag, "_result"}, result, er);
      chk({tag, "_carry"}, carry_out, ec);
      chk({tag, "_busy_done"}, busy, 1);
      @(negedge clk);
      chk({tag, "_done_end"}, done, 0);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   int dpos[$];

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);

      run_op("add5a3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0);
      run_op("addff01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
      run_op("add0000", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      run_op("sub1001", 1'b1, 8'h10, 8'h01, 8'h0F, 1'b0);
      run_op("sub0001", 1'b1, 8'h00, 8'h01, 8'hFF, 1'b1);

      // Idle with start low holds previous outputs.
      repeat (3) @(negedge clk);
      chk("hold_result", result, 8'hFF);
      chk("hold_carry", carry_out, 1);

      // Requests during RUN are ignored.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a_in = 8'h12; b_in = 8'h34;
      @(negedge clk);
      start = 1'b1; op = 1'b1; a_in = 8'hFF; b_in = 8'hFF;
      @(negedge clk);
      chk("ign_mid_result", result, 8'hFF);
      @(negedge clk);
      start = 1'b0;
      begin
         int n;
         n = 0;
         for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
               n = i;
               break;
            end
         end
         chk("ign_seen_done", n != 0, 1);
      end
      chk("ign_result", result, 8'h46);
      chk("ign_carry", carry_out, 0);
      repeat (2) @(negedge clk);
      chk("ign_idle", busy, 0);

      // Reset mid-RUN aborts asynchronously.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a_in = 8'h5A; b_in = 8'h3C;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1 chk("abort_nodone", done, 0);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 0);
      chk("abort_carry", carry_out, 0);
      repeat (2) @(negedge clk);
      chk("abort_hold_done", done, 0);
      rst_n = 1'b1;
      run_op("post_rst", 1'b0, 8'h01, 8'h02, 8'h03, 1'b0);

      // Back-to-back with start held: one op per WIDTH+2 cycles.
      @(negedge clk);
      start = 1'b1; op = 1'b0; a_in = 8'h12; b_in = 8'h34;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            dpos.push_back(i);
            chk("stream_result", result, 8'h46);
         end
      end
      start = 1'b0;
      chk("stream_count", dpos.size(), 3);
      if (dpos.size() == 3) begin
         chk("stream_first", dpos[0], 9);
         chk("stream_gap1", dpos[1] - dpos[0], 10);
         chk("stream_gap2", dpos[2] - dpos[1], 10);
      end
      repeat (3) @(negedge clk);
      chk("stream_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
